alu_share_arb: RTL and testbench



---
 rtl/alu_share_arb_pkg.sv | 38 +++
 rtl/alu_share_arb_if.sv | 34 +++
 rtl/alu_share_arb_rr_arbiter.sv | 54 +++++
 rtl/alu_share_arb.sv | 113 +++++++++++
 tb/tb_alu_share_arb.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared types and widths for the ALU-sharing arbiter slice.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
package alu_share_arb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_MUL  = 4'd10
    } aluop_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    // Registered ALU response held for the current owner
    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
    } alu_rsp_t;

    // Index width that stays at least one bit for a single requester
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester/response handshake bus plus the shared-ALU connection.
// slave = arbiter side, master = requesters and ALU side.
interface alu_share_arb_if
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*XLEN-1:0] req_opr_a;
    logic [NUM_REQ*XLEN-1:0] req_opr_b;
    logic [NUM_REQ*OPW-1:0]  req_aluop;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic [XLEN-1:0]         rsp_res;
    logic                    rsp_zero;
    logic [XLEN-1:0]         alu_opr_a;
    logic [XLEN-1:0]         alu_opr_b;
    logic [OPW-1:0]          alu_aluop;
    logic [XLEN-1:0]         alu_res;
    logic                    alu_zero;

    modport slave (
        input  req_valid, req_opr_a, req_opr_b, req_aluop, rsp_ready, alu_res, alu_zero,
        output req_ready, rsp_valid, rsp_res, rsp_zero, alu_opr_a, alu_opr_b, alu_aluop
    );

    modport master (
        output req_valid, req_opr_a, req_opr_b, req_aluop, rsp_ready, alu_res, alu_zero,
        input  req_ready, rsp_valid, rsp_res, rsp_zero, alu_opr_a, alu_opr_b, alu_aluop
    );

endinterface

// File: rtl/alu_share_arb_rr_arbiter.sv
// One-hot request arbiter: round-robin starting at ptr, or lowest-index-first
// when ALU_ARB_FIXED_PRIO_EN is defined (no pointer input in that build).
module rr_arbiter
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // First set bit from index 0 upward wins
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!any_c && req[i]) begin
                grant_c[i] = 1'b1;
                idx_c      = IW'(i);
                any_c      = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] pos;

    // Scan positions ptr, ptr+1, ... (mod N); idle index follows ptr
    always_comb begin
        grant_c = '0;
        idx_c   = ptr;
        any_c   = 1'b0;
        pos     = ptr;
        for (int k = 0; k < int'(N); k++) begin
            pos = IW'((int'(ptr) + k) % int'(N));
            for (int i = 0; i < int'(N); i++) begin
                if (!any_c && req[i] && (IW'(i) == pos)) begin
                    grant_c[i] = 1'b1;
                    idx_c      = pos;
                    any_c      = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NUM_REQ requesters with a registered, per-owner response.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_share_arb_if.slave bus
);

    localparam int unsigned IW = idx_width(NUM_REQ);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic [IW-1:0]      owner_q;
    alu_rsp_t           rsp_q;
    logic [NUM_REQ-1:0] grant_c;
    logic [IW-1:0]      win_idx_c;
    logic               any_c;
    logic               owner_rdy_c;
    logic               can_accept_c;
    logic               accept_c;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IW-1:0]      rr_ptr_q;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .ptr     (rr_ptr_q),
`endif
        .grant_c (grant_c),
        .idx_c   (win_idx_c),
        .any_c   (any_c)
    );

    // Only the owner's rsp_ready can release the held result
    always_comb begin
        owner_rdy_c = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (IW'(i) == owner_q) begin
                owner_rdy_c = bus.rsp_ready[i];
            end
        end
    end

    assign can_accept_c  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && owner_rdy_c));
    assign accept_c      = can_accept_c && any_c;
    assign bus.req_ready = grant_c & {NUM_REQ{can_accept_c}};
    assign bus.rsp_res   = rsp_q.res;
    assign bus.rsp_zero  = rsp_q.zero;

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.rsp_valid[i] = !rst && (state_q == ST_RESP) && (owner_q == IW'(i));
        end
    end

    // Operand mux follows the arbiter index, which rests on rr_ptr when nobody is granted
    always_comb begin
        bus.alu_opr_a = '0;
        bus.alu_opr_b = '0;
        bus.alu_aluop = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (IW'(i) == win_idx_c) begin
                bus.alu_opr_a = bus.req_opr_a[i*XLEN +: XLEN];
                bus.alu_opr_b = bus.req_opr_b[i*XLEN +: XLEN];
                bus.alu_aluop = bus.req_aluop[i*OPW +: OPW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_RESP;
            ST_RESP: if (owner_rdy_c && !accept_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result capture and ownership transfer on every accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= '0;
            rsp_q    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else if (accept_c) begin
            owner_q  <= win_idx_c;
            rsp_q    <= '{res: bus.alu_res, zero: bus.alu_zero};
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= (win_idx_c == IW'(NUM_REQ - 1)) ? '0 : win_idx_c + IW'(1);
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALU behind it and a response scoreboard.
// Honours ALU_ARB_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int unsigned N = 2;

    typedef struct {
        int unsigned idx;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_arb_if #(.NUM_REQ(N)) bus();

    alu_share_arb #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference ALU sitting behind the arbiter
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        a = bus.alu_opr_a;
        b = bus.alu_opr_b;
        r = 32'h0;
        case (bus.alu_aluop)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            ALU_SLTU: r = (a < b) ? 32'h1 : 32'h0;
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_MUL:  r = a * b;
            default:  r = 32'h0;
        endcase
        bus.alu_res  = r;
        bus.alu_zero = (r == 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int unsigned idx, input logic [31:0] res, input logic zero);
        exp_t e;
        e.idx  = idx;
        e.res  = res;
        e.zero = zero;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic v);
        bus.req_opr_a[i*32 +: 32] = a;
        bus.req_opr_b[i*32 +: 32] = b;
        bus.req_aluop[i*4 +: 4]   = op;
        bus.req_valid[i]          = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every completed response handshake pops one expectation
    always @(negedge clk) begin
        if (!rst && ((bus.rsp_valid & bus.rsp_ready) != '0)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b with nothing expected", bus.rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_owner", 32'(bus.rsp_valid), 32'(1) << mon_e.idx);
                chk("rsp_res", bus.rsp_res, mon_e.res);
                chk("rsp_zero", 32'(bus.rsp_zero), 32'(mon_e.zero));
            end
        end
    end

    logic [1:0] t2_grant [4];

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_opr_a = '0;
        bus.req_opr_b = '0;
        bus.req_aluop = '0;
        bus.rsp_ready = '0;

        // Reset: a valid request during reset must not be accepted
        set_req(0, ALU_ADD, 32'd1, 32'd1, 1'b1);
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        set_req(0, ALU_ADD, 32'd0, 32'd0, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("post_rst_res", bus.rsp_res, 32'h0);
        chk("post_rst_zero", 32'(bus.rsp_zero), 32'h0);

        // 1: single ADD, one-cycle latency
        step();
        set_req(0, ALU_ADD, 32'd5, 32'd7, 1'b1);
        push(0, 32'd12, 1'b0);
        @(negedge clk);
        chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
        step();
        set_req(0, ALU_ADD, 32'd5, 32'd7, 1'b0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("t1_idle", 32'(bus.rsp_valid), 32'h0);

        // Undefined op code yields res=0, zero=1
        step();
        set_req(1, 4'hF, 32'd3, 32'd4, 1'b1);
        push(1, 32'h0, 1'b1);
        @(negedge clk);
        chk("undef_req_ready", 32'(bus.req_ready), 32'h2);
        step();
        set_req(1, 4'hF, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        chk("undef_rsp_valid", 32'(bus.rsp_valid), 32'h2);

        // 2: both requesters continuously valid
        do_reset();
`ifdef ALU_ARB_FIXED_PRIO_EN
        t2_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        t2_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        set_req(0, ALU_SUB, 32'd9, 32'd9, 1'b1);
        set_req(1, ALU_SUB, 32'd9, 32'd9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            push((t2_grant[k] == 2'b10) ? 1 : 0, 32'h0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_grant", 32'(bus.req_ready), 32'(t2_grant[k]));
            step();
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t2_idle", 32'(bus.rsp_valid), 32'h0);

        // 3 and 6: back-pressure on owner 1, non-owner ready ignored
        step();
        bus.rsp_ready = 2'b00;
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
        push(1, 32'd1, 1'b0);
        @(negedge clk);
        chk("t3_req_ready", 32'(bus.req_ready), 32'h2);
        step();
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        set_req(0, ALU_ADD, 32'd3, 32'd4, 1'b1);
        push(0, 32'd7, 1'b0);
        bus.rsp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(bus.rsp_valid), 32'h2);
            chk("t3_hold_res", bus.rsp_res, 32'd1);
            chk("t3_hold_ready", 32'(bus.req_ready), 32'h0);
            step();
        end
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        chk("t3_drain_accept", 32'(bus.req_ready), 32'h1);
        step();
        set_req(0, ALU_ADD, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        chk("t3_next_valid", 32'(bus.rsp_valid), 32'h1);
        step();

        // 4: back-to-back issue from requester 0
        set_req(0, ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b1);
        push(0, 32'h0F0F_0F0F, 1'b0);
        @(negedge clk);
        chk("t4_first_ready", 32'(bus.req_ready), 32'h1);
        step();
        set_req(0, ALU_SRA, 32'h8000_0000, 32'd4, 1'b1);
        push(0, 32'hF800_0000, 1'b0);
        @(negedge clk);
        chk("t4_second_ready", 32'(bus.req_ready), 32'h1);
        step();
        set_req(0, ALU_SRA, 32'h8000_0000, 32'd4, 1'b0);
        @(negedge clk);
        step();

        // 5: reset while a result is held; pointer must restart at requester 0
        bus.rsp_ready = 2'b00;
        set_req(0, ALU_ADD, 32'd1, 32'd1, 1'b1);
        @(negedge clk);
        chk("t5_req_ready", 32'(bus.req_ready), 32'h1);
        step();
        set_req(0, ALU_ADD, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        chk("t5_held", 32'(bus.rsp_valid), 32'h1);
        step();
        rst           = 1'b1;
        bus.rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'd2, 32'd2, 1'b1);
        set_req(1, ALU_ADD, 32'd8, 32'd8, 1'b1);
        push(0, 32'd4, 1'b0);
        push(1, 32'd16, 1'b0);
        @(negedge clk);
        chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("t5_rst_req_ready", 32'(bus.req_ready), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_valid", 32'(bus.rsp_valid), 32'h0);
        chk("t5_post_res", bus.rsp_res, 32'h0);
        chk("t5_post_zero", 32'(bus.rsp_zero), 32'h0);
        chk("t5_first_grant", 32'(bus.req_ready), 32'h1);
        step();
        set_req(0, ALU_ADD, 32'd2, 32'd2, 1'b0);
        @(negedge clk);
        chk("t5_second_grant", 32'(bus.req_ready), 32'h2);
        step();
        set_req(1, ALU_ADD, 32'd8, 32'd8, 1'b0);

        // Drain with a bounded wait
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            step();
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
